// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: word widths, opcode values, decode classes and
// the fetch/decode FSM state type.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  // Instruction class produced by the decoder.
  typedef enum logic [2:0] {
    MEM_REF = 3'd0,
    IOT     = 3'd1,
    OPR_G1  = 3'd2,
    OPR_G2  = 3'd3,
    OPR_G3  = 3'd4
  } op_class_t;

  // Major opcodes, instr[11:9].
  localparam logic [2:0] OP_AND = 3'o0;
  localparam logic [2:0] OP_TAD = 3'o1;
  localparam logic [2:0] OP_ISZ = 3'o2;
  localparam logic [2:0] OP_DCA = 3'o3;
  localparam logic [2:0] OP_JMS = 3'o4;
  localparam logic [2:0] OP_JMP = 3'o5;
  localparam logic [2:0] OP_IOT = 3'o6;
  localparam logic [2:0] OP_OPR = 3'o7;

  // Conventional PDP-8 program start address.
  localparam logic [`ADDR_WIDTH-1:0] START_ADDR_DEFAULT = 12'o0200;

  // Bit positions inside an instruction word.
  localparam int HLT_BIT      = 1;
  localparam int IND_BIT      = 8;
  localparam int CUR_PAGE_BIT = 7;

  // Fetch/decode sequencer states.
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } ifu_state_t;

  // Sequential PC advance; the 12-bit result wraps 7777 -> 0000 naturally.
  function automatic logic [`ADDR_WIDTH-1:0] pc_inc(input logic [`ADDR_WIDTH-1:0] pc);
    return pc + `ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ifu_fetch_decode_if.sv
// Bundle of the IFU's memory read port and its EXEC issue/redirect channel.
//
// Handshake: the IFU raises inst_valid with a decoded instruction and holds
// every decoded field stable until the cycle where inst_valid && exec_ready
// is seen at a rising edge (the accept cycle). exec_pc_load/exec_pc_value are
// only looked at in that accept cycle. The memory read is a one-cycle
// ifu_rd_req pulse; ifu_rd_data must be valid in the following cycle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

interface ifu_fetch_decode_if;
  import pdp8_pkg::*;

  // Memory read port
  logic                   ifu_rd_req;
  logic [`ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [`DATA_WIDTH-1:0] ifu_rd_data;

  // Issue channel towards EXEC
  logic                   inst_valid;
  logic                   exec_ready;
  logic [`DATA_WIDTH-1:0] instr;
  logic [2:0]             opcode;
  op_class_t              op_class;
  logic                   indirect;
  logic [`ADDR_WIDTH-1:0] base_addr;
  logic [`ADDR_WIDTH-1:0] inst_pc;

  // Redirect from EXEC and halt status
  logic                   exec_pc_load;
  logic [`ADDR_WIDTH-1:0] exec_pc_value;
  logic                   halted;

  // The fetch/decode unit side.
  modport master (
    output ifu_rd_req, ifu_rd_addr,
    input  ifu_rd_data,
    output inst_valid, instr, opcode, op_class, indirect, base_addr, inst_pc,
    input  exec_ready, exec_pc_load, exec_pc_value,
    output halted
  );

  // The memory + EXEC side.
  modport slave (
    input  ifu_rd_req, ifu_rd_addr,
    output ifu_rd_data,
    input  inst_valid, instr, opcode, op_class, indirect, base_addr, inst_pc,
    output exec_ready, exec_pc_load, exec_pc_value,
    input  halted
  );

endinterface

// File: rtl/pdp8_instr_decode.sv
// Combinational PDP-8 instruction decoder: classifies the word, extracts the
// indirect flag and forms the page-relative base address using the PC the
// word was fetched from.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp8_instr_decode
  import pdp8_pkg::*;
(
  input  logic [`DATA_WIDTH-1:0] i_instr,
  input  logic [`ADDR_WIDTH-1:0] i_pc,
  output logic [2:0]             o_opcode,
  output op_class_t              o_op_class,
  output logic                   o_indirect,
  output logic [`ADDR_WIDTH-1:0] o_base_addr,
  output logic                   o_is_hlt
);

  logic [2:0] w_opcode;
  logic [4:0] w_page;
  logic       w_unused_pc_low;

  assign w_opcode        = i_instr[11:9];
  assign w_page          = i_pc[11:7];
  // Only the page number of the PC takes part in address formation.
  assign w_unused_pc_low = ^i_pc[6:0];
  assign o_opcode        = w_opcode;

  // Classify the word; only memory-reference forms carry I and an address.
  always_comb begin
    o_op_class  = MEM_REF;
    o_indirect  = 1'b0;
    o_base_addr = '0;
    o_is_hlt    = 1'b0;
    case (w_opcode)
      OP_IOT: o_op_class = IOT;
      OP_OPR: begin
        if (!i_instr[IND_BIT]) begin
          o_op_class = OPR_G1;
        end else if (!i_instr[0]) begin
          o_op_class = OPR_G2;
          o_is_hlt   = i_instr[HLT_BIT];
        end else begin
          o_op_class = OPR_G3;
        end
      end
      default: begin
        o_op_class = MEM_REF;
        o_indirect = i_instr[IND_BIT];
        if (i_instr[CUR_PAGE_BIT]) begin
          o_base_addr = {w_page, i_instr[6:0]};
        end else begin
          o_base_addr = {5'b0, i_instr[6:0]};
        end
      end
    endcase
  end

endmodule

// File: rtl/ifu_fetch_decode.sv
// PDP-8 instruction fetch/decode unit. Owns the PC, issues one memory read
// per instruction, registers the decoded word and offers it to EXEC. A
// complete instruction takes FETCH -> WAIT -> ISSUE, three cycles minimum.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module ifu_fetch_decode
  import pdp8_pkg::*;
#(
  parameter logic [`ADDR_WIDTH-1:0] START_ADDR  = START_ADDR_DEFAULT,
  parameter int                     MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  ifu_fetch_decode_if.master    ifu,
  output ifu_state_t            o_dbg_state
);

  ifu_state_t             r_state;
  logic [`ADDR_WIDTH-1:0] r_pc;
  logic                   r_inst_valid;
  logic [`DATA_WIDTH-1:0] r_instr;
  logic [2:0]             r_opcode;
  op_class_t              r_op_class;
  logic                   r_indirect;
  logic [`ADDR_WIDTH-1:0] r_base_addr;
  logic [`ADDR_WIDTH-1:0] r_inst_pc;
  logic                   r_is_hlt;
  logic                   r_halted;

  logic [2:0]             w_opcode;
  op_class_t              w_op_class;
  logic                   w_indirect;
  logic [`ADDR_WIDTH-1:0] w_base_addr;
  logic                   w_is_hlt;
  logic                   w_accept;

  // Decode the word currently on the read bus against the PC it came from.
  pdp8_instr_decode u_decode (
    .i_instr     (ifu.ifu_rd_data),
    .i_pc        (r_pc),
    .o_opcode    (w_opcode),
    .o_op_class  (w_op_class),
    .o_indirect  (w_indirect),
    .o_base_addr (w_base_addr),
    .o_is_hlt    (w_is_hlt)
  );

  assign w_accept = r_inst_valid & ifu.exec_ready;

  // The request is the FETCH state itself, held off while reset is applied.
  assign ifu.ifu_rd_req  = (r_state == S_FETCH) & ~reset;
  assign ifu.ifu_rd_addr = r_pc;
  assign ifu.inst_valid  = r_inst_valid;
  assign ifu.instr       = r_instr;
  assign ifu.opcode      = r_opcode;
  assign ifu.op_class    = r_op_class;
  assign ifu.indirect    = r_indirect;
  assign ifu.base_addr   = r_base_addr;
  assign ifu.inst_pc     = r_inst_pc;
  assign ifu.halted      = r_halted;
  assign o_dbg_state     = r_state;

  // Fetch/decode sequencer with PC and all registered issue outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= START_ADDR;
      r_inst_valid <= 1'b0;
      r_instr      <= '0;
      r_opcode     <= '0;
      r_op_class   <= MEM_REF;
      r_indirect   <= 1'b0;
      r_base_addr  <= '0;
      r_inst_pc    <= '0;
      r_is_hlt     <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Only a single-cycle memory is supported; read data is due now.
          if (MEM_LATENCY == 1) begin
            r_instr      <= ifu.ifu_rd_data;
            r_opcode     <= w_opcode;
            r_op_class   <= w_op_class;
            r_indirect   <= w_indirect;
            r_base_addr  <= w_base_addr;
            r_is_hlt     <= w_is_hlt;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Everything holds until EXEC takes the instruction.
          if (w_accept) begin
            r_inst_valid <= 1'b0;
            if (ifu.exec_pc_load) begin
              r_pc <= ifu.exec_pc_value;
            end else begin
              r_pc <= pc_inc(r_pc);
            end
            if (r_is_hlt) begin
              r_halted <= 1'b1;
              r_state  <= S_HALTED;
            end else begin
              r_state  <= S_FETCH;
            end
          end
        end
        S_HALTED: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/ifu_fetch_decode.md
Name: ifu_fetch_decode

Overview:
- Instruction fetch/decode unit for the PDP-8 IFD path; sits directly upstream of the instruction memory read port.
- Keeps the PC and issues single-word reads to memory.
- Decodes each returned 12-bit word into opcode class, effective base address and indirect flag.
- Hands the decoded instruction to the EXEC unit over a valid/ready handshake; takes PC redirects back from EXEC.

Parameters:
START_ADDR, 12'o0200, PC value loaded on reset.
MEM_LATENCY, 1, cycles from ifu_rd_req sampled high to ifu_rd_data valid; only 1 is supported.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
ifu_rd_req  output  1  memory read request, one-cycle pulse per fetch
ifu_rd_addr  output  `ADDR_WIDTH  read address, always equals PC
ifu_rd_data  input  `DATA_WIDTH  read data, valid MEM_LATENCY cycles after the request
inst_valid  output  1  decoded instruction available to EXEC
exec_ready  input  1  EXEC accepts the instruction when inst_valid && exec_ready
instr  output  `DATA_WIDTH  raw instruction word
opcode  output  3  instr[11:9]
op_class  output  op_class_t  MEM_REF / IOT / OPR_G1 / OPR_G2 / OPR_G3
indirect  output  1  instr[8]; forced 0 for non-MEM_REF
base_addr  output  `ADDR_WIDTH  effective page address
inst_pc  output  `ADDR_WIDTH  PC of the issued instruction
exec_pc_load  input  1  redirect; honoured only in the accept cycle
exec_pc_value  input  `ADDR_WIDTH  redirect target
halted  output  1  HLT instruction has been accepted

Behaviour:
- Reset (synchronous, active-high):
  - PC=START_ADDR; state=FETCH.
  - ifu_rd_req=0, inst_valid=0, halted=0.
  - instr, opcode, indirect, base_addr, inst_pc = 0; op_class=MEM_REF.
  - Reset asserted mid-fetch or mid-issue aborts the operation. Data returning after reset is ignored.
- FSM states: FETCH, WAIT, ISSUE, HALTED.
- FETCH: ifu_rd_req=1 for exactly this cycle. Next state WAIT.
- WAIT: ifu_rd_req=0. At the clock edge, capture ifu_rd_data into instr, register the decoded fields, set inst_pc=PC and inst_valid=1. Next state ISSUE.
- ISSUE: all outputs hold stable while exec_ready=0. On the accept edge (inst_valid && exec_ready):
  - inst_valid->0.
  - If exec_pc_load=1 in that cycle, PC<=exec_pc_value; otherwise PC<=PC+1, wrapping 12'o7777->12'o0000.
  - Next state is FETCH, or HALTED if the instruction is HLT.
- exec_pc_load outside the accept cycle is ignored.
- HALTED: halted=1, no requests, no valid. Exit only via reset.
- Throughput: 3 cycles per instruction minimum (FETCH, WAIT, ISSUE with exec_ready already high).
- Decode rules:
  - opcode 0-5 -> MEM_REF; 6 -> IOT.
  - opcode 7: instr[8]=0 -> OPR_G1; instr[8]=1 && instr[0]=0 -> OPR_G2; instr[8]=1 && instr[0]=1 -> OPR_G3.
  - MEM_REF base_addr: instr[7]=1 (current page) -> {PC[11:7], instr[6:0]}; instr[7]=0 -> {5'b0, instr[6:0]}. PC here is the PC of the fetched instruction.
  - Non-MEM_REF: base_addr=0.
  - HLT = OPR_G2 with instr[1]=1 (e.g. 12'o7402).
- ifu_rd_addr is a continuous copy of PC. It is stable throughout FETCH/WAIT.

Decomposition:
- Add to pdp8_pkg:
  - op_class_t enum.
  - Opcode constants: AND, TAD, ISZ, DCA, JMS, JMP, IOT, OPR.
  - START_ADDR_DEFAULT, HLT_BIT.
- Reuse the existing `ADDR_WIDTH and `DATA_WIDTH macros.
- One sub-module, pdp8_instr_decode: combinational; inputs instr and pc, outputs opcode, op_class, indirect, base_addr, is_hlt. The FSM and PC stay in ifu_fetch_decode.

Test Plan:
- Reset release, memory returns 12'o7200, exec_ready=1 -> ifu_rd_req pulses with ifu_rd_addr=12'o0200; inst_valid 2 cycles later; op_class=OPR_G1; next fetch addr 12'o0201.
- PC 12'o0200, data 12'o1377 (TAD current page) -> base_addr=12'o0377, indirect=0; data 12'o5105 -> opcode JMP, base_addr=12'o0105.
- exec_ready held 0 for 5 cycles -> inst_valid and all decoded fields stable, no ifu_rd_req; accept in cycle 6 -> next fetch on the following cycle.
- Accept with exec_pc_load=1, exec_pc_value=12'o3000 -> next ifu_rd_addr=12'o3000; exec_pc_load pulsed during WAIT -> ignored, PC+1.
- PC 12'o7777, no redirect -> next fetch addr 12'o0000; data 12'o7402 accepted -> halted=1, no further ifu_rd_req until reset.
- Reset asserted during WAIT -> next cycle inst_valid=0, PC=12'o0200; the stale data word is never issued.
